// File: rtl/uart_servo_pkg.sv
// Shared types and constants for the UART servo command layer.
package uart_servo_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [3:0] NBITS_CFG = 4'd8;

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        CH    = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        CHK   = 3'd4,
        WRITE = 3'd5
    } state_e;

    // Frame check byte: XOR of the three payload bytes.
    function automatic logic [7:0] frame_chk(input logic [7:0] ch,
                                             input logic [7:0] hi,
                                             input logic [7:0] lo);
        return ch ^ hi ^ lo;
    endfunction

endpackage

// File: rtl/uart_servo_cmd_ctrl_if.sv
// Position-command handshake between the command controller and the PWM register bank.
interface uart_servo_cmd_ctrl_if;
    logic        Pos_valid;
    logic        Pos_ready;
    logic [1:0]  Pos_ch;
    logic [15:0] Pos_val;

    modport master (output Pos_valid, output Pos_ch, output Pos_val, input Pos_ready);
    modport slave  (input Pos_valid, input Pos_ch, input Pos_val, output Pos_ready);
endinterface

// File: rtl/uart_rxdone_sync.sv
// Brings the receiver's RxDone flag into the Clk domain and emits a one-cycle byte_evt per rise.
module uart_rxdone_sync (
    input  logic Clk,
    input  logic Rst_n,
    input  logic RxDone,
    output logic byte_evt
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic evt_r;

    // Two-flop synchronizer followed by a registered rising-edge detector.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            evt_r   <= 1'b0;
        end else begin
            sync1_r <= RxDone;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            evt_r   <= sync2_r & ~prev_r;
        end
    end

    assign byte_evt = evt_r;

endmodule

// File: rtl/uart_servo_cmd_ctrl.sv
// Parses A5/CH/HI/LO/CHK frames from the UART receiver into validated servo position commands.
module uart_servo_cmd_ctrl
    import uart_servo_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int POS_MAX       = 2000,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic                        Enable,
    input  logic                        Tick,
    output logic                        RxEn,
    output logic [3:0]                  NBits,
    input  logic                        RxDone,
    input  logic [7:0]                  RxData,
    uart_servo_cmd_ctrl_if.master       pos,
    output logic                        Frame_err,
    output logic [7:0]                  Err_cnt,
    output logic                        Busy
);

    localparam int GAP_W = $clog2(TIMEOUT_TICKS + 1);

    state_e             state_r;
    state_e             state_nx;
    logic               en_r;
    logic               byte_evt_s;
    logic [GAP_W-1:0]   gap_r;
    logic               in_frame_s;
    logic               timeout_s;
    logic               frame_ok_s;
    logic               accept_s;
    logic               reject_s;
    logic               load_s;
    logic [7:0]         ch_r;
    logic [7:0]         hi_r;
    logic [7:0]         lo_r;
    logic               pos_valid_r;
    logic [1:0]         pos_ch_r;
    logic [15:0]        pos_val_r;
    logic               frame_err_r;
    logic [7:0]         err_cnt_r;
    logic               busy_r;

    uart_rxdone_sync u_sync (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .RxDone   (RxDone),
        .byte_evt (byte_evt_s)
    );

    assign in_frame_s = (state_r == CH) || (state_r == HI) || (state_r == LO) || (state_r == CHK);
    assign timeout_s  = (gap_r == GAP_W'(TIMEOUT_TICKS));
    assign frame_ok_s = (RxData == frame_chk(ch_r, hi_r, lo_r)) &&
                        (ch_r < 8'(NUM_CH)) &&
                        ({hi_r, lo_r} <= 16'(POS_MAX));
    assign accept_s   = pos_valid_r & pos.Pos_ready;

    // Next-state logic; a byte arriving in the timeout cycle takes priority over the timeout.
    always_comb begin
        state_nx = state_r;
        reject_s = 1'b0;
        load_s   = 1'b0;
        if (!Enable) begin
            state_nx = SYNC;
        end else begin
            case (state_r)
                SYNC: begin
                    if (byte_evt_s && (RxData == SYNC_BYTE)) state_nx = CH;
                    else                                     state_nx = SYNC;
                end
                CH: begin
                    if (byte_evt_s)     state_nx = HI;
                    else if (timeout_s) begin reject_s = 1'b1; state_nx = SYNC; end
                    else                state_nx = CH;
                end
                HI: begin
                    if (byte_evt_s)     state_nx = LO;
                    else if (timeout_s) begin reject_s = 1'b1; state_nx = SYNC; end
                    else                state_nx = HI;
                end
                LO: begin
                    if (byte_evt_s)     state_nx = CHK;
                    else if (timeout_s) begin reject_s = 1'b1; state_nx = SYNC; end
                    else                state_nx = LO;
                end
                CHK: begin
                    if (byte_evt_s) begin
                        if (frame_ok_s) begin load_s = 1'b1; state_nx = WRITE; end
                        else            begin reject_s = 1'b1; state_nx = SYNC; end
                    end else if (timeout_s) begin
                        reject_s = 1'b1;
                        state_nx = SYNC;
                    end else begin
                        state_nx = CHK;
                    end
                end
                WRITE: begin
                    reject_s = byte_evt_s;
                    if (accept_s) state_nx = SYNC;
                    else          state_nx = WRITE;
                end
                default: state_nx = SYNC;
            endcase
        end
    end

    // State, status outputs and the saturating reject counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= SYNC;
            en_r        <= 1'b0;
            busy_r      <= 1'b0;
            pos_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            err_cnt_r   <= 8'd0;
        end else begin
            state_r     <= state_nx;
            en_r        <= Enable;
            busy_r      <= (state_nx != SYNC);
            pos_valid_r <= (state_nx == WRITE);
            frame_err_r <= reject_s;
            if (reject_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
            else                                  err_cnt_r <= err_cnt_r;
        end
    end

    // Payload capture and the command registers presented to the register bank.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ch_r      <= 8'd0;
            hi_r      <= 8'd0;
            lo_r      <= 8'd0;
            pos_ch_r  <= 2'd0;
            pos_val_r <= 16'd0;
        end else begin
            if (Enable && byte_evt_s) begin
                case (state_r)
                    CH:      ch_r <= RxData;
                    HI:      hi_r <= RxData;
                    LO:      lo_r <= RxData;
                    default: ch_r <= ch_r;
                endcase
            end else begin
                ch_r <= ch_r;
            end
            if (load_s) begin
                pos_ch_r  <= ch_r[1:0];
                pos_val_r <= {hi_r, lo_r};
            end else begin
                pos_val_r <= pos_val_r;
            end
        end
    end

    // Inter-byte gap counter, only live while a frame is partially received.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            gap_r <= '0;
        end else if (!Enable || !in_frame_s || byte_evt_s) begin
            gap_r <= '0;
        end else if (Tick && !timeout_s) begin
            gap_r <= gap_r + GAP_W'(1'b1);
        end else begin
            gap_r <= gap_r;
        end
    end

    assign RxEn          = en_r;
    assign NBits         = NBITS_CFG;
    assign pos.Pos_valid = pos_valid_r;
    assign pos.Pos_ch    = pos_ch_r;
    assign pos.Pos_val   = pos_val_r;
    assign Frame_err     = frame_err_r;
    assign Err_cnt       = err_cnt_r;
    assign Busy          = busy_r;

endmodule

// File: tb/tb_uart_servo_cmd_ctrl.sv
// Directed and randomized bench for uart_servo_cmd_ctrl against a byte-queue frame model.
module tb_uart_servo_cmd_ctrl;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Enable = 1'b0;
    logic       Tick = 1'b0;
    logic       RxDone = 1'b0;
    logic [7:0] RxData = 8'h00;
    logic       RxEn;
    logic [3:0] NBits;
    logic       Frame_err;
    logic [7:0] Err_cnt;
    logic       Busy;

    uart_servo_cmd_ctrl_if pos ();

    uart_servo_cmd_ctrl #(.NUM_CH(4), .POS_MAX(2000), .TIMEOUT_TICKS(640)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Enable    (Enable),
        .Tick      (Tick),
        .RxEn      (RxEn),
        .NBits     (NBits),
        .RxDone    (RxDone),
        .RxData    (RxData),
        .pos       (pos),
        .Frame_err (Frame_err),
        .Err_cnt   (Err_cnt),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: bytes of the frame being assembled, expected commands and rejects.
    logic [7:0]  buf_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    int          exp_err = 0;
    int          exp_pulses = 0;
    int          got_pulses = 0;
    bit          pending = 1'b0;

    // Observe accepted commands and Frame_err pulses mid-cycle.
    always @(negedge Clk) begin
        if (Rst_n) begin
            if (pos.Pos_valid && pos.Pos_ready) got_q.push_back({pos.Pos_ch, pos.Pos_val});
            if (Frame_err) got_pulses++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic model_reject();
        exp_pulses++;
        if (exp_err < 255) exp_err++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [15:0] v;
        if (pending) begin
            model_reject();
        end else if (buf_q.size() == 0) begin
            if (b == 8'hA5) buf_q.push_back(b);
        end else begin
            buf_q.push_back(b);
            if (buf_q.size() == 5) begin
                v = {buf_q[2], buf_q[3]};
                if ((buf_q[4] == (buf_q[1] ^ buf_q[2] ^ buf_q[3])) && (buf_q[1] < 8'd4) && (v <= 16'd2000)) begin
                    exp_q.push_back({buf_q[1][1:0], v});
                    pending = 1'b1;
                end else begin
                    model_reject();
                end
                buf_q.delete();
            end
        end
    endtask

    task automatic model_timeout();
        if (buf_q.size() != 0) begin
            model_reject();
            buf_q.delete();
        end
    endtask

    // One receiver byte; optionally a Tick lands in the same cycle the byte event is seen.
    task automatic send_byte(input logic [7:0] b, input bit tick_on_evt);
        RxData = b;
        RxDone = 1'b1;
        cyc();
        cyc();
        if (tick_on_evt) Tick = 1'b1;
        cyc();
        Tick = 1'b0;
        cyc();
        RxDone = 1'b0;
        cyc();
        cyc();
        cyc();
        model_byte(b);
        if (pos.Pos_ready) pending = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] chk);
        send_byte(8'hA5, 1'b0);
        send_byte(ch, 1'b0);
        send_byte(hi, 1'b0);
        send_byte(lo, 1'b0);
        send_byte(chk, 1'b0);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            Tick = 1'b1;
            cyc();
            Tick = 1'b0;
            cyc();
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_err_cnt"}, {24'd0, Err_cnt}, exp_err);
        check({tag, "_err_pulses"}, got_pulses, exp_pulses);
        check({tag, "_cmd_count"}, got_q.size(), exp_q.size());
        while ((got_q.size() != 0) && (exp_q.size() != 0))
            check({tag, "_cmd"}, {14'd0, got_q.pop_front()}, {14'd0, exp_q.pop_front()});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rxen"},      {31'd0, RxEn},          32'd0);
        check({tag, "_nbits"},     {28'd0, NBits},         32'd8);
        check({tag, "_pos_valid"}, {31'd0, pos.Pos_valid}, 32'd0);
        check({tag, "_pos_ch"},    {30'd0, pos.Pos_ch},    32'd0);
        check({tag, "_pos_val"},   {16'd0, pos.Pos_val},   32'd0);
        check({tag, "_frame_err"}, {31'd0, Frame_err},     32'd0);
        check({tag, "_err_cnt"},   {24'd0, Err_cnt},       32'd0);
        check({tag, "_busy"},      {31'd0, Busy},          32'd0);
    endtask

    initial begin
        logic [7:0]  rch;
        logic [15:0] rv;
        logic [7:0]  rchk;
        logic [7:0]  garb;

        pos.Pos_ready = 1'b0;
        cyc();
        cyc();
        check_reset_outputs("reset");
        Rst_n = 1'b1;
        Enable = 1'b1;
        pos.Pos_ready = 1'b1;
        cyc();
        cyc();
        check("rxen_on", {31'd0, RxEn}, 32'd1);

        send_frame(8'h02, 8'h03, 8'hE8, 8'hE9);
        check_state("good");

        // Backpressure with an overrun byte while the command waits.
        pos.Pos_ready = 1'b0;
        send_frame(8'h02, 8'h03, 8'hE8, 8'hE9);
        check("bp_valid", {31'd0, pos.Pos_valid}, 32'd1);
        send_byte(8'h11, 1'b0);
        check("bp_overrun_err", {24'd0, Err_cnt}, 32'd1);
        repeat (20) cyc();
        check("bp_valid_held", {31'd0, pos.Pos_valid}, 32'd1);
        check("bp_ch_held", {30'd0, pos.Pos_ch}, 32'd2);
        check("bp_val_held", {16'd0, pos.Pos_val}, 32'd1000);
        pos.Pos_ready = 1'b1;
        cyc();
        cyc();
        pending = 1'b0;
        check("bp_valid_drop", {31'd0, pos.Pos_valid}, 32'd0);
        check_state("bp");

        send_frame(8'h01, 8'h00, 8'h10, 8'h00);
        check_state("bad_chk");
        send_frame(8'h07, 8'h00, 8'h10, 8'h17);
        check_state("bad_ch");
        send_frame(8'h00, 8'h07, 8'hD1, 8'hD6);
        check_state("bad_val");

        // Timeout exactly at 640 Ticks, then resync.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        tick_n(639);
        check("to_busy_639", {31'd0, Busy}, 32'd1);
        check("to_err_639", {24'd0, Err_cnt}, exp_err);
        tick_n(1);
        cyc();
        model_timeout();
        check("to_busy_640", {31'd0, Busy}, 32'd0);
        send_frame(8'h01, 8'h03, 8'hE8, 8'hEA);
        check_state("timeout");

        // A byte event in the same cycle the gap reaches 640 is kept.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        tick_n(639);
        send_byte(8'h03, 1'b1);
        send_byte(8'hE8, 1'b0);
        send_byte(8'hEA, 1'b0);
        check_state("byte_wins");

        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_frame(8'h03, 8'h07, 8'hD0, 8'hD4);
        check_state("garbage_max");

        // Asynchronous reset mid-frame.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        check("rst_pre_busy", {31'd0, Busy}, 32'd1);
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        buf_q.delete();
        exp_err = 0;
        pending = 1'b0;
        cyc();
        Rst_n = 1'b1;
        cyc();
        send_byte(8'h03, 1'b0);
        send_byte(8'hE8, 1'b0);
        send_byte(8'hEA, 1'b0);
        check_state("rst_discard");

        // Enable low mid-frame and during a pending command.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        Enable = 1'b0;
        cyc();
        buf_q.delete();
        check("en_busy", {31'd0, Busy}, 32'd0);
        check("en_rxen", {31'd0, RxEn}, 32'd0);
        Enable = 1'b1;
        cyc();
        send_byte(8'h03, 1'b0);
        send_byte(8'hE8, 1'b0);
        send_byte(8'hEA, 1'b0);
        pos.Pos_ready = 1'b0;
        send_frame(8'h02, 8'h03, 8'hE8, 8'hE9);
        check("en_write_valid", {31'd0, pos.Pos_valid}, 32'd1);
        Enable = 1'b0;
        cyc();
        check("en_write_drop", {31'd0, pos.Pos_valid}, 32'd0);
        void'(exp_q.pop_back());
        pending = 1'b0;
        Enable = 1'b1;
        pos.Pos_ready = 1'b1;
        cyc();
        cyc();
        check_state("enable");

        for (int i = 0; i < 40; i++) begin
            rch  = 8'($urandom_range(0, 5));
            rv   = 16'($urandom_range(0, 2100));
            rchk = rch ^ rv[15:8] ^ rv[7:0];
            if ($urandom_range(0, 3) == 0) rchk = rchk ^ 8'h5A;
            if ($urandom_range(0, 2) == 0) begin
                garb = 8'($urandom_range(0, 255));
                if (garb == 8'hA5) garb = 8'h00;
                send_byte(garb, 1'b0);
            end
            send_frame(rch, rv[15:8], rv[7:0], rchk);
        end
        check_state("random");

        for (int i = 0; i < 260; i++) send_frame(8'h01, 8'h00, 8'h10, 8'h00);
        check("sat_255", {24'd0, Err_cnt}, 32'd255);
        check_state("saturate");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_servo_cmd_ctrl.md
# uart_servo_cmd_ctrl

Command-layer controller that sits directly above the UART receiver in the servo datapath. It enables the receiver, fixes its word length, and turns the received byte stream into validated 4-byte servo position commands. Each accepted command is handed to the servo PWM register bank over a valid/ready handshake. Malformed, out-of-range or timed-out frames are dropped and counted.

## Interface
- NUM_CH, 4: number of servo channels; legal channel ids are 0..NUM_CH-1.
- POS_MAX, 2000: largest legal position value.
- TIMEOUT_TICKS, 640: Tick pulses allowed between bytes inside a frame (about 40 bit times).
- Clk  in  1  system clock
- Rst_n  in  1  reset, asynchronous, active-low
- Enable  in  1  command reception enable
- Tick  in  1  baud×16 pulse, one Clk cycle wide, synchronous to Clk
- RxEn  out  1  receiver enable; equals registered Enable
- NBits  out  4  receiver word length; constant 4'd8
- RxDone  in  1  receiver byte-done flag; from the Tick domain, treated as asynchronous
- RxData  in  8  received byte; stable while RxDone is high
- Pos_valid  out  1  command available
- Pos_ready  in  1  register bank accepts the command
- Pos_ch  out  2  channel id
- Pos_val  out  16  position
- Frame_err  out  1  one-cycle pulse on any frame rejection
- Err_cnt  out  8  saturating rejection count
- Busy  out  1  high in any state other than SYNC

## Operation
- Frame format: 0xA5, CH, HI, LO, CHK.
  - CHK = CH ^ HI ^ LO.
  - Position = {HI, LO}.
- RxDone passes through a 2-flop synchronizer and a rising-edge detector to form byte_evt.
  - RxData is sampled only on byte_evt.
- States and transitions:
  - SYNC: byte 0xA5 → CH; any other byte is discarded silently, with no error.
  - CH: store the byte → HI.
  - HI: store the byte → LO.
  - LO: store the byte → CHK.
  - CHK: if the byte equals the computed checksum, CH < NUM_CH and {HI,LO} <= POS_MAX → WRITE. Otherwise reject → SYNC.
  - WRITE: drive Pos_valid until Pos_valid & Pos_ready → SYNC.
- Reject action: Frame_err pulses for 1 cycle and Err_cnt increments, saturating at 255.
- Timeout:
  - The gap counter clears on every byte_evt and increments on each Tick while in CH, HI, LO or CHK.
  - When it reaches TIMEOUT_TICKS the frame is rejected → SYNC.
  - If byte_evt and timeout occur in the same cycle, the byte wins.
- Overrun: a byte_evt in WRITE is dropped and counted as a reject. The state stays WRITE and Pos_* are unchanged.
- Enable low:
  - Takes effect on the next cycle: RxEn goes low, the state forces to SYNC and any partial frame is discarded without error.
  - A pending WRITE is abandoned and Pos_valid drops.
- Pos_ch and Pos_val are registered. They are stable while Pos_valid is high and hold their last value otherwise.

## Timing
- Reset values:
  - state SYNC, RxEn 0, NBits 8, Pos_valid 0, Pos_ch 0, Pos_val 0, Frame_err 0, Err_cnt 0, Busy 0.
  - Synchronizer, edge and gap-counter registers are 0.
- RxDone rise → byte_evt: 3 Clk cycles.
- CHK byte_evt → Pos_valid high: 1 cycle.
- Handshake:
  - Pos_valid, once high, stays high until accepted.
  - Acceptance happens in a cycle with Pos_valid & Pos_ready; Pos_valid is low the next cycle.
  - Pos_ready may be high before Pos_valid, which gives a 1-cycle accept.
- Frame_err is asserted the cycle after the rejecting byte_evt or timeout.
- Rst_n asserted mid-frame or mid-WRITE returns everything to reset values immediately (asynchronous).

## Structure
- Shared package uart_servo_pkg holds:
  - SYNC_BYTE = 8'hA5
  - state enum {SYNC, CH, HI, LO, CHK, WRITE}
  - NBITS_CFG = 4'd8
- One sub-module: uart_rxdone_sync, holding the 2-flop synchronizer and rising-edge detector that produces byte_evt.
- Everything else (FSM, checksum, gap counter, error counter) is in the top level.

## Test plan
- Good frame: Enable=1, Pos_ready=1, bytes A5 02 03 E8 E9 → Pos_valid pulses once with Pos_ch=2, Pos_val=1000; Err_cnt stays 0.
- Backpressure: same frame with Pos_ready=0 for 20 cycles, plus an extra byte 0x11 during WRITE → Pos_valid held with values stable; Err_cnt=1; the command is accepted when Pos_ready rises.
- Bad checksum / bad channel / value over POS_MAX:
  - A5 01 00 10 00 → Frame_err pulse, Err_cnt=1.
  - A5 07 00 10 17 → Err_cnt=2.
  - A5 00 07 D1 D6 → Err_cnt=3.
  - None of the three produces Pos_valid.
- Timeout then resync: A5 01 followed by silence longer than 640 Ticks → Err_cnt +1, state SYNC; the next full good frame is accepted.
- Garbage and boundaries: bytes 00 FF A5 03 07 D0 D4 → the two leading bytes are ignored without error and Pos_ch=3, Pos_val=2000 is accepted. Separately, a byte_evt coinciding with the timeout cycle is accepted as a byte.
- Reset and Enable mid-frame:
  - Rst_n low after A5 01 → all outputs return to reset values.
  - Enable low after A5 01 → state SYNC with no error.
  - 260 bad frames → Err_cnt saturates at 255.
